lut_function_unit: RTL

Programmable NIN-input Boolean function evaluator: a loadable truth table feeding a registered 2^NIN-to-1 selection. It generalises our fixed-function mux implementations to any function of NIN variables, reconfigurable at run time. A serial configuration port loads a new table into a shadow register and commits it atomically, so evaluations are never glitched by a half-loaded table. It sits between a configuration master (bit-serial) and any datapath needing a registered, swappable logic function.

---
 rtl/lut_function_unit_pkg.sv | 18 +
 rtl/lut_select_mux.sv | 33 +++
 rtl/lut_function_unit.sv | 106 ++++++++++
 3 files changed

// File: rtl/lut_function_unit_pkg.sv
// Shared types and sizing helpers for the
// programmable LUT function unit.
package lut_function_unit_pkg;

  function automatic int tbl_w(input int nin);
    return 1 << nin;
  endfunction

  function automatic int cnt_w(input int nin);
    return $clog2(tbl_w(nin)) + 1;
  endfunction

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } load_state_e;

endpackage

// File: rtl/lut_select_mux.sv
// Combinational 2^NIN-to-1 table selector built from
// per-pair residues of the LSB variable.
module lut_select_mux
  import lut_function_unit_pkg::*;
#(
  parameter int NIN = 4
) (
  input  logic [tbl_w(NIN)-1:0] tbl,
  input  logic [NIN-1:0]        sel,
  output logic                  f
);

  localparam int W = tbl_w(NIN);
  localparam int L = W / 2;

  logic [L-1:0] leg;

  // each leg collapses a minterm pair to 0, 1, v0 or ~v0
  always_comb begin
    leg = '0;
    for (int j = 0; j < L; j++) begin
      unique case ({tbl[2*j+1], tbl[2*j]})
        2'b00: leg[j] = 1'b0;
        2'b11: leg[j] = 1'b1;
        2'b10: leg[j] = sel[0];
        2'b01: leg[j] = ~sel[0];
      endcase
    end
  end

  assign f = leg[sel[NIN-1:1]];

endmodule

// File: rtl/lut_function_unit.sv
// Run-time loadable NIN-input Boolean function with
// shadow/active tables and a registered evaluation.
module lut_function_unit
  import lut_function_unit_pkg::*;
#(
  parameter int NIN = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cfg_start,
  input  logic           cfg_en,
  input  logic           cfg_bit,
  output logic           cfg_busy,
  output logic           cfg_done,
  output logic           tbl_loaded,
  input  logic           in_valid,
  input  logic [NIN-1:0] in_vars,
  output logic           out_valid,
  output logic           out_f
);

  localparam int W  = tbl_w(NIN);
  localparam int CW = cnt_w(NIN);

  load_state_e   state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [W-1:0]  shadow, shadow_n;
  logic [W-1:0]  active;
  logic          commit;
  logic          f_sel;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    shadow_n = shadow;
    commit   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (cfg_start) begin
          state_n  = ST_LOAD;
          cnt_n    = '0;
          shadow_n = '0;
        end
      end
      ST_LOAD: begin
        // a restart beats a shift, even the final one
        priority case (1'b1)
          cfg_start: begin
            cnt_n    = '0;
            shadow_n = '0;
          end
          cfg_en: begin
            shadow_n = {shadow[W-2:0], cfg_bit};
            cnt_n    = cnt + 1'b1;
            if (cnt == CW'(W - 1)) begin
              commit  = 1'b1;
              state_n = ST_IDLE;
            end
          end
          default: ;
        endcase
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      shadow     <= '0;
      active     <= '0;
      cfg_done   <= 1'b0;
      tbl_loaded <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      shadow   <= shadow_n;
      cfg_done <= commit;
      if (commit) begin
        active     <= shadow_n;
        tbl_loaded <= 1'b1;
      end
    end
  end

  lut_select_mux #(
    .NIN (NIN)
  ) u_mux (
    .tbl (active),
    .sel (in_vars),
    .f   (f_sel)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_f     <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) out_f <= f_sel;
    end
  end

  assign cfg_busy = (state == ST_LOAD);

endmodule
